// File: rtl/mfp_ahb_pkg.sv
// rtl/mfp_ahb_pkg.sv - AHB-Lite encodings, slave FSM states and lane-mask helper
package mfp_ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_LAST,
        S_ERR1,
        S_ERR2
    } state_t;

    // Sizes above a word fall through to a full-word mask when errors are disabled.
    function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] addr_lo);
        case (size)
            HSIZE_BYTE: lane_mask = 4'b0001 << addr_lo;
            HSIZE_HALF: lane_mask = addr_lo[1] ? 4'b1100 : 4'b0011;
            default:    lane_mask = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/mfp_ram_be.sv
// rtl/mfp_ram_be.sv - 32-bit RAM with per-byte write enable and registered read
module mfp_ram_be #(
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [3:0]            be,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [31:0]           wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [31:0]           rdata
);

    logic [31:0] mem [2**ADDR_WIDTH];

    // Read returns the pre-write contents when both addresses collide.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we && be[i]) begin
                mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/mfp_ahb_ram_wait.sv
// rtl/mfp_ahb_ram_wait.sv - AHB-Lite RAM slave with programmable read/write wait states
module mfp_ahb_ram_wait
    import mfp_ahb_pkg::*;
#(
    parameter int ADDR_WIDTH = 6,
    parameter int READ_WAIT  = 2,
    parameter int WRITE_WAIT = 2,
    parameter int ERR_ENABLE = 1
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic [31:0] HADDR,
    input  logic [2:0]  HBURST,
    input  logic        HMASTLOCK,
    input  logic [3:0]  HPROT,
    input  logic        HSEL,
    input  logic [2:0]  HSIZE,
    input  logic [1:0]  HTRANS,
    input  logic [31:0] HWDATA,
    input  logic        HWRITE,
    output logic [31:0] HRDATA,
    output logic        HREADY,
    output logic        HRESP,
    input  logic        SI_Endian
);

    state_t                state, state_n;
    logic [3:0]            cnt, cnt_n;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  wr_q;
    logic [3:0]            mask_q;
    logic [ADDR_WIDTH-1:0] haddr_idx;
    logic [ADDR_WIDTH-1:0] raddr;
    logic                  accept;
    logic                  misaligned;
    logic                  err_req;
    logic [3:0]            wait_ld;
    logic                  ram_we;
    logic [31:0]           ram_q;
    logic [31:0]           byp_data;
    logic [3:0]            byp_mask;
    logic                  unused_inputs;

    assign unused_inputs = ^{HBURST, HMASTLOCK, HPROT, HTRANS[0], SI_Endian, HADDR[31:ADDR_WIDTH+2]};

    assign haddr_idx  = HADDR[ADDR_WIDTH+1:2];
    assign HREADY     = !(state == S_WAIT || state == S_ERR1);
    assign HRESP      = (state == S_ERR1 || state == S_ERR2) ? HRESP_ERROR : HRESP_OKAY;
    assign accept     = HSEL && (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ) && HREADY;
    assign misaligned = (HSIZE > HSIZE_WORD)
                     || (HSIZE == HSIZE_HALF && HADDR[0])
                     || (HSIZE == HSIZE_WORD && HADDR[1:0] != 2'b00);
    assign err_req    = (ERR_ENABLE != 0) && misaligned;
    assign wait_ld    = HWRITE ? 4'(WRITE_WAIT) : 4'(READ_WAIT);
    assign ram_we     = (state == S_LAST) && wr_q;
    // A zero-wait read must hit the RAM during its address phase.
    assign raddr      = accept ? haddr_idx : addr_q;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state  <= S_IDLE;
            cnt    <= 4'd0;
            addr_q <= '0;
            wr_q   <= 1'b0;
            mask_q <= 4'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (accept) begin
                addr_q <= haddr_idx;
                wr_q   <= HWRITE && !err_req;
                mask_q <= lane_mask(HSIZE, HADDR[1:0]);
            end
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            S_WAIT: begin
                cnt_n = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state_n = S_LAST;
                end
            end
            S_ERR1:  state_n = S_ERR2;
            default: state_n = S_IDLE;
        endcase
        if (accept) begin
            if (err_req) begin
                state_n = S_ERR1;
            end else if (wait_ld == 4'd0) begin
                state_n = S_LAST;
            end else begin
                state_n = S_WAIT;
                cnt_n   = wait_ld;
            end
        end
    end

    // Remember lanes committed in the same cycle the RAM was read at that word.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            byp_mask <= 4'd0;
            byp_data <= 32'd0;
        end else begin
            byp_mask <= (ram_we && raddr == addr_q) ? mask_q : 4'd0;
            byp_data <= HWDATA;
        end
    end

    always_comb begin
        HRDATA = 32'd0;
        if (state == S_LAST && !wr_q) begin
            for (int i = 0; i < 4; i++) begin
                HRDATA[8*i +: 8] = byp_mask[i] ? byp_data[8*i +: 8] : ram_q[8*i +: 8];
            end
        end
    end

    mfp_ram_be #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk   (HCLK),
        .we    (ram_we),
        .be    (mask_q),
        .waddr (addr_q),
        .wdata (HWDATA),
        .raddr (raddr),
        .rdata (ram_q)
    );

endmodule

// File: tb/tb_mfp_ahb_ram_wait.sv
// tb/tb_mfp_ahb_ram_wait.sv - bench for two RAM slaves (2/2 and 0/0 wait states)
module tb_mfp_ahb_ram_wait;
    import mfp_ahb_pkg::*;

    localparam int WAIT0 = 2;

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [2:0]  sz;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_resp;
        int          exp_waits;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        hsel   [2];
    logic        hwrite [2];
    logic [1:0]  htrans [2];
    logic [2:0]  hsize  [2];
    logic [31:0] haddr  [2];
    logic [31:0] hwdata [2];
    logic [31:0] hrdata [2];
    logic        hready [2];
    logic        hresp  [2];

    logic [31:0] mdl [2][64];
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mfp_ahb_ram_wait #(.ADDR_WIDTH(6), .READ_WAIT(WAIT0), .WRITE_WAIT(WAIT0), .ERR_ENABLE(1)) dut (
        .HCLK(clk), .HRESETn(rst_n), .HADDR(haddr[0]), .HBURST(3'b000), .HMASTLOCK(1'b0),
        .HPROT(4'b0011), .HSEL(hsel[0]), .HSIZE(hsize[0]), .HTRANS(htrans[0]), .HWDATA(hwdata[0]),
        .HWRITE(hwrite[0]), .HRDATA(hrdata[0]), .HREADY(hready[0]), .HRESP(hresp[0]), .SI_Endian(1'b0)
    );

    mfp_ahb_ram_wait #(.ADDR_WIDTH(6), .READ_WAIT(0), .WRITE_WAIT(0), .ERR_ENABLE(1)) dut0 (
        .HCLK(clk), .HRESETn(rst_n), .HADDR(haddr[1]), .HBURST(3'b000), .HMASTLOCK(1'b0),
        .HPROT(4'b0011), .HSEL(hsel[1]), .HSIZE(hsize[1]), .HTRANS(htrans[1]), .HWDATA(hwdata[1]),
        .HWRITE(hwrite[1]), .HRDATA(hrdata[1]), .HREADY(hready[1]), .HRESP(hresp[1]), .SI_Endian(1'b0)
    );

    function automatic int exp_wait(input int k, input logic w);
        return (k == 0) ? WAIT0 : 0;
    endfunction

    function automatic logic ref_err(input logic [2:0] sz, input logic [31:0] a);
        if (sz > 3'd2) return 1'b1;
        return (a % (32'd1 << sz)) != 0;
    endfunction

    function automatic int ref_idx(input logic [31:0] a);
        return int'((a / 4) % 64);
    endfunction

    // Lanes covered: 2**size bytes starting at the size-aligned byte offset.
    function automatic logic [3:0] ref_mask(input logic [2:0] sz, input logic [31:0] a);
        int nbytes, start;
        nbytes = 1 << sz;
        start  = int'(a % 4) - int'(a % 4) % nbytes;
        return 4'(((1 << nbytes) - 1) << start);
    endfunction

    task automatic model_write(input int k, input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd);
        logic [3:0] m;
        m = ref_mask(sz, a);
        for (int b = 0; b < 4; b++) begin
            if (m[b]) mdl[k][ref_idx(a)][8*b +: 8] = wd[8*b +: 8];
        end
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus(input int k);
        hsel[k]   = 1'b0;
        htrans[k] = HTRANS_IDLE;
        hwrite[k] = 1'b0;
    endtask

    task automatic addr_phase(input int k, input logic w, input logic [31:0] a, input logic [2:0] sz);
        hsel[k]   = 1'b1;
        htrans[k] = HTRANS_NONSEQ;
        hwrite[k] = w;
        haddr[k]  = a;
        hsize[k]  = sz;
    endtask

    task automatic wait_ready(input int k, output int waits);
        waits = 0;
        while (!hready[k] && waits < 40) begin
            waits++;
            tick();
        end
        if (!hready[k]) begin
            n_checks++;
            n_fail++;
            $display("FAIL hready_timeout: inst %0d still not ready after %0d cycles", k, waits);
        end
    endtask

    task automatic xfer(input int k, input logic w, input logic [31:0] a, input logic [2:0] sz,
                        input logic [31:0] wd, output logic [31:0] rd, output logic rs, output int waits);
        addr_phase(k, w, a, sz);
        tick();
        idle_bus(k);
        hwdata[k] = wd;
        wait_ready(k, waits);
        rd = hrdata[k];
        rs = hresp[k];
        tick();
    endtask

    task automatic check_xfer(input int k, input string nm, input logic w, input logic [31:0] a,
                              input logic [2:0] sz, input logic [31:0] wd);
        logic [31:0] rd, exp_rd;
        logic        rs, e;
        int          wt;
        e      = ref_err(sz, a);
        exp_rd = mdl[k][ref_idx(a)];
        xfer(k, w, a, sz, wd, rd, rs, wt);
        check({nm, "_resp"}, 32'(rs), 32'(e));
        check({nm, "_waits"}, wt, e ? 1 : exp_wait(k, w));
        if (!w && !e) check({nm, "_rdata"}, rd, exp_rd);
        if (w && !e) model_write(k, a, sz, wd);
    endtask

    // Write immediately followed by a read; the read address phase overlaps the write's last cycle.
    task automatic b2b(input int k, input string nm, input logic [31:0] wa, input logic [2:0] wsz,
                       input logic [31:0] wd, input logic [31:0] ra);
        int w1, w2;
        addr_phase(k, 1'b1, wa, wsz);
        tick();
        hwdata[k] = wd;
        addr_phase(k, 1'b0, ra, HSIZE_WORD);
        wait_ready(k, w1);
        check({nm, "_wwaits"}, w1, exp_wait(k, 1'b1));
        model_write(k, wa, wsz, wd);
        tick();
        idle_bus(k);
        wait_ready(k, w2);
        check({nm, "_rwaits"}, w2, exp_wait(k, 1'b0));
        check({nm, "_rdata"}, hrdata[k], mdl[k][ref_idx(ra)]);
        check({nm, "_resp"}, 32'(hresp[k]), 32'(HRESP_OKAY));
        tick();
    endtask

    function automatic logic [31:0] legal_addr(input logic [2:0] sz);
        logic [31:0] a;
        a = $urandom_range(0, 511);
        return a & ~((32'd1 << sz) - 1);
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t tbl[$];
        logic [31:0] rd;
        logic        rs;
        int          wt;

        tbl.push_back('{1'b1, 32'h10,  HSIZE_WORD, 32'hDEADBEEF, 32'h0,        1'b0, 2});
        tbl.push_back('{1'b0, 32'h10,  HSIZE_WORD, 32'h0,        32'hDEADBEEF, 1'b0, 2});
        tbl.push_back('{1'b1, 32'h0,   HSIZE_WORD, 32'h11223344, 32'h0,        1'b0, 2});
        tbl.push_back('{1'b1, 32'h2,   HSIZE_BYTE, 32'h00AA0000, 32'h0,        1'b0, 2});
        tbl.push_back('{1'b1, 32'h0,   HSIZE_HALF, 32'h00005566, 32'h0,        1'b0, 2});
        tbl.push_back('{1'b0, 32'h0,   HSIZE_WORD, 32'h0,        32'h11AA5566, 1'b0, 2});
        tbl.push_back('{1'b1, 32'h2,   HSIZE_WORD, 32'hFFFFFFFF, 32'h0,        1'b1, 1});
        tbl.push_back('{1'b0, 32'h0,   HSIZE_WORD, 32'h0,        32'h11AA5566, 1'b0, 2});
        tbl.push_back('{1'b1, 32'h1,   HSIZE_HALF, 32'h0000FFFF, 32'h0,        1'b1, 1});
        tbl.push_back('{1'b0, 32'h0,   3'd3,       32'h0,        32'h0,        1'b1, 1});
        tbl.push_back('{1'b0, 32'h3,   HSIZE_BYTE, 32'h0,        32'h11AA5566, 1'b0, 2});
        tbl.push_back('{1'b1, 32'h100, HSIZE_WORD, 32'hCAFEF00D, 32'h0,        1'b0, 2});
        tbl.push_back('{1'b0, 32'h0,   HSIZE_WORD, 32'h0,        32'hCAFEF00D, 1'b0, 2});
        tbl.push_back('{1'b1, 32'h13,  HSIZE_BYTE, 32'h77000000, 32'h0,        1'b0, 2});
        tbl.push_back('{1'b0, 32'h10,  HSIZE_WORD, 32'h0,        32'h77ADBEEF, 1'b0, 2});
        tbl.push_back('{1'b1, 32'h12,  HSIZE_HALF, 32'h12340000, 32'h0,        1'b0, 2});
        tbl.push_back('{1'b0, 32'h10,  HSIZE_WORD, 32'h0,        32'h1234BEEF, 1'b0, 2});

        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            idle_bus(k);
            haddr[k]  = 32'h0;
            hsize[k]  = HSIZE_WORD;
            hwdata[k] = 32'h0;
        end
        #2;
        for (int k = 0; k < 2; k++) begin
            check("reset_hready", 32'(hready[k]), 32'd1);
            check("reset_hresp", 32'(hresp[k]), 32'd0);
            check("reset_hrdata", hrdata[k], 32'd0);
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 64; i++) check_xfer(k, "init", 1'b1, 32'(i * 4), HSIZE_WORD, $urandom);
        end

        foreach (tbl[i]) begin
            xfer(0, tbl[i].w, tbl[i].a, tbl[i].sz, tbl[i].wd, rd, rs, wt);
            check($sformatf("vec%0d_resp", i), 32'(rs), 32'(tbl[i].exp_resp));
            check($sformatf("vec%0d_waits", i), wt, tbl[i].exp_waits);
            if (!tbl[i].w && !tbl[i].exp_resp) check($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rd);
            if (tbl[i].w && !tbl[i].exp_resp) model_write(0, tbl[i].a, tbl[i].sz, tbl[i].wd);
        end

        // Error response followed by a transfer presented during the second error cycle.
        addr_phase(0, 1'b1, 32'h2, HSIZE_WORD);
        tick();
        idle_bus(0);
        hwdata[0] = 32'hFFFFFFFF;
        check("err1_hready", 32'(hready[0]), 32'd0);
        check("err1_hresp", 32'(hresp[0]), 32'd1);
        tick();
        check("err2_hready", 32'(hready[0]), 32'd1);
        check("err2_hresp", 32'(hresp[0]), 32'd1);
        addr_phase(0, 1'b0, 32'h0, HSIZE_WORD);
        tick();
        idle_bus(0);
        wait_ready(0, wt);
        check("after_err_waits", wt, WAIT0);
        check("after_err_hresp", 32'(hresp[0]), 32'd0);
        check("after_err_rdata", hrdata[0], mdl[0][0]);
        tick();

        // Reset in the middle of a write's wait states drops the write.
        check_xfer(0, "pre_rst_w", 1'b1, 32'h8, HSIZE_WORD, 32'h12345678);
        addr_phase(0, 1'b1, 32'h8, HSIZE_WORD);
        tick();
        idle_bus(0);
        hwdata[0] = 32'h0BADF00D;
        check("rst_wait_hready", 32'(hready[0]), 32'd0);
        rst_n = 1'b0;
        #1;
        check("rst_async_hready", 32'(hready[0]), 32'd1);
        check("rst_async_hresp", 32'(hresp[0]), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check_xfer(0, "post_rst_r", 1'b0, 32'h8, HSIZE_WORD, 32'h0);

        // Selected but IDLE: no transfer, bus stays ready.
        hsel[0]   = 1'b1;
        htrans[0] = HTRANS_IDLE;
        hwrite[0] = 1'b1;
        haddr[0]  = 32'h10;
        hwdata[0] = 32'h0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_hready", 32'(hready[0]), 32'd1);
            check("idle_hresp", 32'(hresp[0]), 32'd0);
        end
        idle_bus(0);
        check_xfer(0, "idle_r", 1'b0, 32'h10, HSIZE_WORD, 32'h0);

        // Zero-wait back-to-back write/read through the bypass path.
        check_xfer(1, "zw_pre", 1'b1, 32'h4, HSIZE_WORD, 32'h11111111);
        b2b(1, "zw_word", 32'h4, HSIZE_WORD, 32'hA5A50001, 32'h4);
        check("zw_word_value", mdl[1][1], 32'hA5A50001);
        b2b(1, "zw_byte", 32'h5, HSIZE_BYTE, 32'h00007700, 32'h4);
        check("zw_byte_value", mdl[1][1], 32'hA5A57701);

        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 20; i++) begin
                logic [2:0]  sz;
                logic [31:0] wa, ra;
                sz = 3'($urandom_range(0, 2));
                wa = legal_addr(sz);
                ra = ($urandom_range(0, 1) == 1) ? (wa & ~32'h3) : legal_addr(HSIZE_WORD);
                b2b(k, "rnd_b2b", wa, sz, $urandom, ra);
            end
            for (int i = 0; i < 60; i++) begin
                check_xfer(k, "rnd", 1'($urandom_range(0, 1)), 32'($urandom_range(0, 511)),
                           3'($urandom_range(0, 3)), $urandom);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
